key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
Conditions raw board push-buttons into the clean, active-high key levels consumed by the cursor-traversal logic of the minesweeper design.
- Per key: synchronise, debounce, then optionally auto-repeat while held.
- Auto-repeat works by inserting one-cycle low gaps, so a rising-edge detector downstream sees repeated presses.
- Sits between the board KEY pins and the traversal block's input_keys bus.

Parameters:
NKEYS, 4, number of independent key channels
SYNC_STAGES, 2, synchroniser flops per key (>=2)
DEBOUNCE_CYCLES, 500000, consecutive cycles a changed level must hold before acceptance (10 ms at 50 MHz; >=1)
REPEAT_DELAY_CYCLES, 25000000, cycles held before first auto-repeat (>=1)
REPEAT_PERIOD_CYCLES, 5000000, auto-repeat period, 1 low gap cycle plus (PERIOD-1) high cycles (>=2)
ACTIVE_LOW_IN, 1, 1 = raw pins read 0 when pressed; 0 = raw pins read 1 when pressed

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
keys_raw  input  NKEYS  asynchronous raw button pins
repeat_en  input  1  1 = auto-repeat enabled for all keys (sampled every cycle)
keys_out  output  NKEYS  conditioned level, 1 = pressed; drives traversal input_keys
press_pulse  output  NKEYS  one-cycle pulse on every 0->1 of keys_out

Behaviour:
Interface: reset rst, synchronous, active-low; clock clk.

Reset (rst==0 at posedge clk):
- All synchroniser flops load the released level.
- Debounce state = released; all counters and timers = 0; channel FSMs = IDLE.
- keys_out = 0; press_pulse = 0.
- A key physically held through reset is treated as a fresh press after reset: keys_out rises SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after rst goes high.

Normalisation: pressed = ACTIVE_LOW_IN ? ~keys_raw : keys_raw, applied at the synchroniser input.

Debounce (per key):
- If sync_out != stable, cnt increments; else cnt clears to 0.
- When cnt == DEBOUNCE_CYCLES-1 and sync_out != stable, stable <= sync_out and cnt <= 0.
- cnt width = clog2(DEBOUNCE_CYCLES)+1; cnt never wraps.
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count, so stable does not change.

Latency:
- Raw level change to stable update: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- keys_out is registered from the FSM, so it changes one cycle after stable.

Channel FSM (per key, timer width sized for max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)):
- IDLE: keys_out=0. On stable==1 -> DELAY, timer=0.
- DELAY: keys_out=1.
  - stable==0 -> IDLE.
  - Else if repeat_en==1 and timer==REPEAT_DELAY_CYCLES-1 -> GAP.
  - Else timer++ (timer holds at 0 while repeat_en==0).
- GAP: keys_out=0 for exactly one cycle.
  - stable==0 -> IDLE.
  - Else -> REPEAT, timer=0.
- REPEAT: keys_out=1.
  - stable==0 -> IDLE.
  - repeat_en==0 -> DELAY, timer=0.
  - timer==REPEAT_PERIOD_CYCLES-2 -> GAP.
  - Else timer++.

press_pulse:
- Asserted for one cycle coincident with each keys_out 0->1 edge (IDLE->DELAY, GAP->REPEAT).
- It is never asserted on a falling edge.

Boundary conditions:
- Channels are fully independent; simultaneous presses, releases and repeats on several keys produce concurrent independent outputs.
- Release during GAP: keys_out stays 0 and the FSM goes to IDLE; no extra pulse.
- repeat_en deasserted mid-repeat: keys_out stays 1 until release; no further gaps.
- Reset overrides every state at the same edge.

Decomposition:
- Shared package minesweeper_pkg:
  - Key index constants KEY_UP=0 (y-1), KEY_DOWN=1 (y+1), KEY_LEFT=2 (x-1), KEY_RIGHT=3 (x+1).
  - Channel FSM state encoding IDLE/DELAY/GAP/REPEAT.
  - Default timing constants for the 50 MHz board clock.
- One natural sub-module, key_channel: synchroniser, debouncer and FSM for a single key.
- The top level generates NKEYS instances of key_channel.

Test Plan:
Use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=6, ACTIVE_LOW_IN=1.

1. Clean press: keys_raw[0] 1->0 at cycle 0, held 8 cycles, repeat_en=0 -> keys_out[0] rises at cycle 7, press_pulse[0]=1 at cycle 7 only; keys_out[0] falls 7 cycles after release.
2. Bounce: keys_raw[1] toggled low 3 cycles, high 1, low 3, high -> keys_out[1] stays 0, press_pulse[1] never asserts.
3. Auto-repeat: keys_raw[3] held low 40 cycles, repeat_en=1 -> keys_out[3] high cycles 7-16, low at 17, high 18-22, low 23, high 24-28, low 29 …; press_pulse[3] at 7, 18, 24, 30.
4. Simultaneous: keys 0 and 2 pressed same cycle, key 2 released 20 cycles later -> both outputs rise at cycle 7; key 0 unaffected by key 2's release.
5. Reset mid-hold: rst=0 for 1 cycle while key 0 held and keys_out[0]=1 -> next cycle keys_out=0, press_pulse=0; keys_out[0] re-rises 7 cycles after rst returns to 1.
6. Release in GAP / repeat_en drop: release timed so stable falls during GAP -> no extra press_pulse; separately, drop repeat_en during REPEAT -> keys_out stays 1 with no gaps until release.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper design: key indices on the
// traversal input_keys bus, key-channel FSM encoding and default timing
// for the 50 MHz board clock.
package minesweeper_pkg;

  // Bit positions on the traversal input_keys bus
  localparam int KEY_UP    = 0;  // y-1
  localparam int KEY_DOWN  = 1;  // y+1
  localparam int KEY_LEFT  = 2;  // x-1
  localparam int KEY_RIGHT = 3;  // x+1
  localparam int NUM_KEYS  = 4;

  // Per-key conditioning state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_GAP    = 2'd2,
    ST_REPEAT = 2'd3
  } key_state_e;

  // Default timing at 50 MHz
  localparam int DEF_SYNC_STAGES          = 2;
  localparam int DEF_DEBOUNCE_CYCLES      = 500_000;     // 10 ms
  localparam int DEF_REPEAT_DELAY_CYCLES  = 25_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD_CYCLES = 5_000_000;   // 100 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: normalise, synchronise, debounce, then an FSM
// that produces the held level with optional one-cycle auto-repeat gaps.
module key_channel
  import minesweeper_pkg::*;
#(
  parameter int SYNC_STAGES          = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter int ACTIVE_LOW_IN        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic repeat_en,
  output logic key_out,
  output logic press_pulse
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TIMER_W = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD_CYCLES - 2);

  logic                   key_pressed;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic                   stable_reg;
  logic [CNT_W-1:0]       cnt_reg;
  key_state_e             state_reg;
  logic [TIMER_W-1:0]     timer_reg;
  logic                   key_out_reg;
  logic                   pulse_reg;

  // Everything downstream of the pin works in "1 = pressed"
  assign key_pressed = (ACTIVE_LOW_IN != 0) ? ~key_raw : key_raw;
  assign sync_out    = sync_reg[SYNC_STAGES-1];

  // Synchroniser chain; reset loads the released level
  always_ff @(posedge clk) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_pressed};
  end

  // Debounce: accept a new level only after it has differed from stable
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count
  always_ff @(posedge clk) begin
    if (!rst) begin
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (sync_out != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync_out;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  // Channel FSM with registered level and press pulse; the pulse is raised
  // on exactly the transitions that raise the level
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      key_out_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (stable_reg) begin
            state_reg   <= ST_DELAY;
            timer_reg   <= '0;
            key_out_reg <= 1'b1;
            pulse_reg   <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (!stable_reg) begin
            state_reg   <= ST_IDLE;
            key_out_reg <= 1'b0;
          end else if (!repeat_en) begin
            timer_reg <= '0;
          end else if (timer_reg == DELAY_LAST) begin
            state_reg   <= ST_GAP;
            key_out_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        ST_GAP: begin
          if (!stable_reg) begin
            state_reg <= ST_IDLE;
          end else begin
            state_reg   <= ST_REPEAT;
            timer_reg   <= '0;
            key_out_reg <= 1'b1;
            pulse_reg   <= 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!stable_reg) begin
            state_reg   <= ST_IDLE;
            key_out_reg <= 1'b0;
          end else if (!repeat_en) begin
            state_reg <= ST_DELAY;
            timer_reg <= '0;
          end else if (timer_reg == PERIOD_LAST) begin
            state_reg   <= ST_GAP;
            key_out_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          key_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign key_out     = key_out_reg;
  assign press_pulse = pulse_reg;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw board push-buttons into clean active-high key levels for
// the cursor-traversal block; one independent key_channel per key.
module key_conditioner
  import minesweeper_pkg::*;
#(
  parameter int NKEYS                = NUM_KEYS,
  parameter int SYNC_STAGES          = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter int ACTIVE_LOW_IN        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keys_raw,
  input  logic             repeat_en,
  output logic [NKEYS-1:0] keys_out,
  output logic [NKEYS-1:0] press_pulse
);

  // One fully independent conditioning channel per key
  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      key_channel #(
        .SYNC_STAGES         (SYNC_STAGES),
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
        .ACTIVE_LOW_IN       (ACTIVE_LOW_IN)
      ) u_channel (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (keys_raw[gi]),
        .repeat_en  (repeat_en),
        .key_out    (keys_out[gi]),
        .press_pulse(press_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing: sync 2, debounce 4,
// repeat delay 10, repeat period 6, active-low pins. Cycle c is the interval
// after a rising edge; inputs set in cycle c are sampled at its closing edge.
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] keys_raw;
  logic       repeat_en;
  logic [3:0] keys_out;
  logic [3:0] press_pulse;

  int total;
  int bad;

  key_conditioner #(
    .NKEYS               (4),
    .SYNC_STAGES         (2),
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (10),
    .REPEAT_PERIOD_CYCLES(6),
    .ACTIVE_LOW_IN       (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_raw   (keys_raw),
    .repeat_en  (repeat_en),
    .keys_out   (keys_out),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  // Check both outputs for the current cycle, then advance one cycle
  task automatic step(input string tag, input int c, input logic [3:0] eo, input logic [3:0] ep);
    chk({tag, "_out"}, c, keys_out, eo);
    chk({tag, "_pulse"}, c, press_pulse, ep);
    tick();
  endtask

  task automatic idle(input int n);
    keys_raw  = 4'hF;
    repeat_en = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [3:0] eo;
    logic [3:0] ep;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    keys_raw  = 4'h0;   // all pressed during reset
    repeat_en = 1'b0;
    tick(); tick(); tick();
    chk("reset_out", 0, keys_out, 4'h0);
    chk("reset_pulse", 0, press_pulse, 4'h0);
    keys_raw = 4'hF;
    rst      = 1'b1;
    for (int c = 0; c < 12; c++) step("post_reset", c, 4'h0, 4'h0);
    $display("step reset done");

    // 1. Clean press on key 0, held 8 cycles, no repeat
    for (int c = 0; c <= 20; c++) begin
      keys_raw = (c < 8) ? 4'b1110 : 4'b1111;
      eo = {3'b000, (c >= 7 && c <= 14)};
      ep = {3'b000, (c == 7)};
      step("clean_press", c, eo, ep);
    end
    idle(5);
    $display("step clean_press done");

    // 2. Bounce on key 1: low 3, high 1, low 3, then high
    for (int c = 0; c <= 15; c++) begin
      keys_raw = ((c <= 2) || (c >= 4 && c <= 6)) ? 4'b1101 : 4'b1111;
      step("bounce", c, 4'h0, 4'h0);
    end
    idle(5);
    $display("step bounce done");

    // 3. Auto-repeat on key 3 held 40 cycles
    repeat_en = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      keys_raw = (c < 40) ? 4'b0111 : 4'b1111;
      eo = 4'h0;
      ep = 4'h0;
      if (c >= 7 && c <= 16) eo[3] = 1'b1;
      if (c >= 17 && c <= 46 && ((c - 17) % 6) != 0) eo[3] = 1'b1;
      if (c == 7 || (c >= 18 && c <= 46 && ((c - 18) % 6) == 0)) ep[3] = 1'b1;
      step("auto_repeat", c, eo, ep);
    end
    idle(5);
    $display("step auto_repeat done");

    // 4. Keys 0 and 2 together; key 2 released at 20, key 0 at 30
    for (int c = 0; c <= 40; c++) begin
      keys_raw = 4'hF;
      if (c < 30) keys_raw[0] = 1'b0;
      if (c < 20) keys_raw[2] = 1'b0;
      eo = 4'h0;
      ep = 4'h0;
      eo[0] = (c >= 7 && c <= 36);
      eo[2] = (c >= 7 && c <= 26);
      ep[0] = (c == 7);
      ep[2] = (c == 7);
      step("simultaneous", c, eo, ep);
    end
    idle(5);
    $display("step simultaneous done");

    // 5. Reset pulse in cycle 10 while key 0 is held and high
    for (int c = 0; c <= 36; c++) begin
      rst      = (c == 10) ? 1'b0 : 1'b1;
      keys_raw = (c < 26) ? 4'b1110 : 4'b1111;
      eo = {3'b000, ((c >= 7 && c <= 10) || (c >= 18 && c <= 32))};
      ep = {3'b000, (c == 7 || c == 18)};
      step("reset_mid_hold", c, eo, ep);
    end
    idle(5);
    $display("step reset_mid_hold done");

    // 6a. Key 1 released so that stable falls in the GAP cycle
    repeat_en = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      keys_raw = (c < 11) ? 4'b1101 : 4'b1111;
      eo = {2'b00, (c >= 7 && c <= 16), 1'b0};
      ep = {2'b00, (c == 7), 1'b0};
      step("release_in_gap", c, eo, ep);
    end
    idle(5);
    $display("step release_in_gap done");

    // 6b. Key 2 repeating, repeat_en dropped in REPEAT at cycle 20
    for (int c = 0; c <= 50; c++) begin
      repeat_en = (c < 20);
      keys_raw  = (c < 40) ? 4'b1011 : 4'b1111;
      eo = {1'b0, ((c >= 7 && c <= 16) || (c >= 18 && c <= 46)), 2'b00};
      ep = {1'b0, (c == 7 || c == 18), 2'b00};
      step("repeat_drop", c, eo, ep);
    end
    idle(3);
    $display("step repeat_drop done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
